// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared 64-bit data-memory port between instruction fetch and load/store.
// LS has priority; a starvation counter lets a waiting IF win after STARVE_LIMIT lost cycles.
module mem_port_arbiter #(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_req_valid_i,
   output logic            if_req_ready_o,
   input  logic [XLEN-1:0] if_addr_i,
   output logic            if_resp_valid_o,
   output logic [XLEN-1:0] if_rdata_o,
   input  logic            ls_req_valid_i,
   output logic            ls_req_ready_o,
   input  logic [XLEN-1:0] ls_addr_i,
   input  logic            ls_wen_i,
   input  logic [XLEN-1:0] ls_wdata_i,
   input  logic [7:0]      ls_wstrb_i,
   output logic            ls_resp_valid_o,
   output logic [XLEN-1:0] ls_rdata_o,
   output logic            mem_req_valid_o,
   input  logic            mem_req_ready_i,
   output logic [XLEN-1:0] mem_addr_o,
   output logic            mem_wen_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [7:0]      mem_wstrb_o,
   input  logic            mem_resp_valid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   logic [1:0]      state_q, state_d;
   logic            owner_q, owner_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic            mem_req_valid_q, mem_req_valid_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic            mem_wen_q, mem_wen_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
   logic [7:0]      mem_wstrb_q, mem_wstrb_d;
   logic            if_resp_valid_q, if_resp_valid_d;
   logic            ls_resp_valid_q, ls_resp_valid_d;
   logic [XLEN-1:0] if_rdata_q, if_rdata_d;
   logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;
   logic            grant_if_c, grant_ls_c;
   logic            starved_c;

   assign starved_c = (starve_q == CNT_W'(STARVE_LIMIT));

   // Next-state, arbitration and transaction latching.
   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      starve_d        = starve_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_addr_d      = mem_addr_q;
      mem_wen_d       = mem_wen_q;
      mem_wdata_d     = mem_wdata_q;
      mem_wstrb_d     = mem_wstrb_q;
      if_resp_valid_d = 1'b0;
      ls_resp_valid_d = 1'b0;
      if_rdata_d      = if_rdata_q;
      ls_rdata_d      = ls_rdata_q;
      grant_if_c      = 1'b0;
      grant_ls_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ls_req_valid_i && !(if_req_valid_i && starved_c)) begin
               grant_ls_c = 1'b1;
            end else if (if_req_valid_i) begin
               grant_if_c = 1'b1;
            end

            if (grant_ls_c) begin
               owner_d         = OWN_LS;
               mem_addr_d      = {ls_addr_i[XLEN-1:3], 3'b000};
               mem_wen_d       = ls_wen_i;
               mem_wdata_d     = ls_wdata_i;
               mem_wstrb_d     = ls_wen_i ? ls_wstrb_i : 8'h00;
               mem_req_valid_d = 1'b1;
               state_d         = ST_ISSUE;
               if (if_req_valid_i && !starved_c) begin
                  starve_d = starve_q + CNT_W'(1);
               end
            end else if (grant_if_c) begin
               owner_d         = OWN_IF;
               mem_addr_d      = {if_addr_i[XLEN-1:3], 3'b000};
               mem_wen_d       = 1'b0;
               mem_wdata_d     = '0;
               mem_wstrb_d     = 8'h00;
               mem_req_valid_d = 1'b1;
               state_d         = ST_ISSUE;
               starve_d        = '0;
            end
         end

         ST_ISSUE: begin
            if (mem_req_ready_i) begin
               mem_req_valid_d = 1'b0;
               state_d         = ST_WAIT;
            end
         end

         ST_WAIT: begin
            // Writes are acknowledged through the same LS response path.
            if (mem_resp_valid_i) begin
               state_d = ST_IDLE;
               if (owner_q == OWN_IF) begin
                  if_resp_valid_d = 1'b1;
                  if_rdata_d      = mem_rdata_i;
               end else begin
                  ls_resp_valid_d = 1'b1;
                  ls_rdata_d      = mem_rdata_i;
               end
            end
         end

         default: begin
            state_d         = ST_IDLE;
            mem_req_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         owner_q         <= OWN_IF;
         starve_q        <= '0;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= '0;
         mem_wen_q       <= 1'b0;
         mem_wdata_q     <= '0;
         mem_wstrb_q     <= 8'h00;
         if_resp_valid_q <= 1'b0;
         ls_resp_valid_q <= 1'b0;
         if_rdata_q      <= '0;
         ls_rdata_q      <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         starve_q        <= starve_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_addr_q      <= mem_addr_d;
         mem_wen_q       <= mem_wen_d;
         mem_wdata_q     <= mem_wdata_d;
         mem_wstrb_q     <= mem_wstrb_d;
         if_resp_valid_q <= if_resp_valid_d;
         ls_resp_valid_q <= ls_resp_valid_d;
         if_rdata_q      <= if_rdata_d;
         ls_rdata_q      <= ls_rdata_d;
      end
   end

   // Ready is a same-cycle grant; held low while reset is asserted.
   assign if_req_ready_o  = grant_if_c & rst_n;
   assign ls_req_ready_o  = grant_ls_c & rst_n;
   assign if_resp_valid_o = if_resp_valid_q;
   assign ls_resp_valid_o = ls_resp_valid_q;
   assign if_rdata_o      = if_rdata_q;
   assign ls_rdata_o      = ls_rdata_q;
   assign mem_req_valid_o = mem_req_valid_q;
   assign mem_addr_o      = mem_addr_q;
   assign mem_wen_o       = mem_wen_q;
   assign mem_wdata_o     = mem_wdata_q;
   assign mem_wstrb_o     = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: requester driver, memory responder and
// response monitor run as separate processes sharing expected-value queues.
module tb_mem_port_arbiter;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned LIMIT = 4;
   localparam int          NEVER = 32'h7fff_ffff;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            if_req_valid_i = 1'b0;
   logic            if_req_ready_o;
   logic [XLEN-1:0] if_addr_i = '0;
   logic            if_resp_valid_o;
   logic [XLEN-1:0] if_rdata_o;
   logic            ls_req_valid_i = 1'b0;
   logic            ls_req_ready_o;
   logic [XLEN-1:0] ls_addr_i = '0;
   logic            ls_wen_i = 1'b0;
   logic [XLEN-1:0] ls_wdata_i = '0;
   logic [7:0]      ls_wstrb_i = '0;
   logic            ls_resp_valid_o;
   logic [XLEN-1:0] ls_rdata_o;
   logic            mem_req_valid_o;
   logic            mem_req_ready_i = 1'b0;
   logic [XLEN-1:0] mem_addr_o;
   logic            mem_wen_o;
   logic [XLEN-1:0] mem_wdata_o;
   logic [7:0]      mem_wstrb_o;
   logic            mem_resp_valid_i = 1'b0;
   logic [XLEN-1:0] mem_rdata_i = '0;

   mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o), .if_addr_i(if_addr_i),
      .if_resp_valid_o(if_resp_valid_o), .if_rdata_o(if_rdata_o),
      .ls_req_valid_i(ls_req_valid_i), .ls_req_ready_o(ls_req_ready_o), .ls_addr_i(ls_addr_i),
      .ls_wen_i(ls_wen_i), .ls_wdata_i(ls_wdata_i), .ls_wstrb_i(ls_wstrb_i),
      .ls_resp_valid_o(ls_resp_valid_o), .ls_rdata_o(ls_rdata_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
      .mem_wstrb_o(mem_wstrb_o), .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic            own;      // 0 = IF, 1 = LS
      logic [XLEN-1:0] addr;
      logic            wen;
      logic [XLEN-1:0] wdata;
      logic [7:0]      wstrb;
      int              gcyc;     // cycle of the accepting edge
   } req_t;

   typedef struct {
      logic            own;
      logic [XLEN-1:0] rdata;
      int              at;       // cycle in which the pulse must be visible
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];

   int checks = 0;
   int failures = 0;

   bit run = 0;
   bit gen_en = 0;
   int p_new = 50;
   int idle_at = 0;
   int starve_m = 0;
   bit if_pend = 0;
   bit ls_pend = 0;
   logic [XLEN-1:0] if_rd_m = '0;
   logic [XLEN-1:0] ls_rd_m = '0;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic [XLEN-1:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Requester driver and arbitration reference: the grant rule is evaluated per request.
   initial begin
      bit idle, g_if, g_ls;
      req_t r;
      forever begin
         @(negedge clk);
         if (run) begin
            if (!if_pend && gen_en && $urandom_range(99) < p_new) begin
               if_pend   = 1;
               if_addr_i = rand64();
            end
            if (!ls_pend && gen_en && $urandom_range(99) < p_new) begin
               ls_pend    = 1;
               ls_addr_i  = rand64();
               ls_wen_i   = 1'($urandom_range(1));
               ls_wdata_i = rand64();
               ls_wstrb_i = 8'($urandom);
            end
            if_req_valid_i = if_pend;
            ls_req_valid_i = ls_pend;
            #1;
            idle = (cyc >= idle_at);
            g_ls = idle && ls_pend && !(if_pend && starve_m == LIMIT);
            g_if = idle && if_pend && !g_ls;
            check("if_req_ready", if_req_ready_o, g_if);
            check("ls_req_ready", ls_req_ready_o, g_ls);
            if (g_ls) begin
               r.own   = 1'b1;
               r.addr  = ls_addr_i & ~64'h7;
               r.wen   = ls_wen_i;
               r.wdata = ls_wdata_i;
               r.wstrb = ls_wen_i ? ls_wstrb_i : 8'h00;
               r.gcyc  = cyc;
               req_q.push_back(r);
               if (if_pend && starve_m < LIMIT) starve_m++;
               ls_pend = 0;
               idle_at = NEVER;
            end
            if (g_if) begin
               r.own   = 1'b0;
               r.addr  = if_addr_i & ~64'h7;
               r.wen   = 1'b0;
               r.wdata = '0;
               r.wstrb = 8'h00;
               r.gcyc  = cyc;
               req_q.push_back(r);
               starve_m = 0;
               if_pend  = 0;
               idle_at  = NEVER;
            end
         end
      end
   end

   // Memory model: random stalls and latency, spurious responses outside the wait window.
   initial begin
      bit armed = 0, outstanding = 0, saw_valid = 0;
      int delay = 0;
      req_t cur;
      rsp_t e;
      logic [XLEN-1:0] s_addr, s_wdata;
      logic s_wen;
      logic [7:0] s_wstrb;
      forever begin
         @(negedge clk);
         if (run) begin
            mem_resp_valid_i = 1'b0;
            if (armed) begin
               armed = 0;
               check("mem_req_valid_drop", mem_req_valid_o, 1'b0);
               outstanding = 1;
               delay = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
            end
            if (outstanding) begin
               if (delay == 0) begin
                  e.own   = cur.own;
                  e.rdata = rand64();
                  e.at    = cyc + 1;
                  mem_resp_valid_i = 1'b1;
                  mem_rdata_i      = e.rdata;
                  rsp_q.push_back(e);
                  idle_at     = cyc + 1;
                  outstanding = 0;
               end else begin
                  delay--;
               end
            end else if ($urandom_range(9) == 0) begin
               mem_resp_valid_i = 1'b1;
               mem_rdata_i      = rand64();
            end

            if (mem_req_valid_o) begin
               if (!saw_valid) begin
                  saw_valid = 1;
                  if (req_q.size() == 0) begin
                     fail("unexpected_mem_req");
                     cur.own = 1'b0;
                  end else begin
                     cur = req_q.pop_front();
                     check("issue_latency", 64'(cyc), 64'(cur.gcyc + 1));
                     check("mem_addr", mem_addr_o, cur.addr);
                     check("mem_wen", mem_wen_o, cur.wen);
                     check("mem_wdata", mem_wdata_o, cur.wdata);
                     check("mem_wstrb", mem_wstrb_o, cur.wstrb);
                  end
                  s_addr = mem_addr_o; s_wen = mem_wen_o;
                  s_wdata = mem_wdata_o; s_wstrb = mem_wstrb_o;
               end else begin
                  check("stall_stable", {mem_addr_o, mem_wdata_o, mem_wstrb_o, 7'd0, mem_wen_o},
                        {s_addr, s_wdata, s_wstrb, 7'd0, s_wen});
               end
               mem_req_ready_i = ($urandom_range(99) < 60);
               if (mem_req_ready_i) begin
                  armed = 1;
                  saw_valid = 0;
               end
            end else begin
               mem_req_ready_i = 1'($urandom_range(1));
            end
         end
      end
   end

   // Response monitor: pops the scoreboard on every pulse, checks held rdata every cycle.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (if_resp_valid_o || ls_resp_valid_o) begin
               if (rsp_q.size() == 0) begin
                  fail("spurious_resp_pulse");
               end else begin
                  e = rsp_q.pop_front();
                  check("resp_if_pulse", if_resp_valid_o, !e.own);
                  check("resp_ls_pulse", ls_resp_valid_o, e.own);
                  check("resp_cycle", 64'(cyc), 64'(e.at));
                  if (e.own) ls_rd_m = e.rdata;
                  else       if_rd_m = e.rdata;
               end
            end else if (rsp_q.size() > 0 && cyc > rsp_q[0].at) begin
               fail("missing_resp_pulse");
               void'(rsp_q.pop_front());
            end
            check("if_rdata", if_rdata_o, if_rd_m);
            check("ls_rdata", ls_rdata_o, ls_rd_m);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {58'd0, if_req_ready_o, ls_req_ready_o, if_resp_valid_o,
                            ls_resp_valid_o, mem_req_valid_o, mem_wen_o}, '0);
      check({tag, "_mem_addr"}, mem_addr_o, '0);
      check({tag, "_mem_wdata"}, mem_wdata_o, '0);
      check({tag, "_mem_wstrb"}, 64'(mem_wstrb_o), '0);
      check({tag, "_if_rdata"}, if_rdata_o, '0);
      check({tag, "_ls_rdata"}, ls_rdata_o, '0);
   endtask

   // Hand-driven IF read; optionally resets while the arbiter waits for the response.
   task automatic manual_if_read(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                                 input bit reset_in_wait);
      rsp_t e;
      @(negedge clk);
      if_req_valid_i = 1'b1;
      if_addr_i      = addr;
      #1;
      check("man_if_ready", if_req_ready_o, 1'b1);
      check("man_ls_ready", ls_req_ready_o, 1'b0);
      @(negedge clk);
      if_req_valid_i = 1'b0;
      check("man_mem_valid", mem_req_valid_o, 1'b1);
      check("man_mem_addr", mem_addr_o, addr & ~64'h7);
      check("man_mem_wen", mem_wen_o, 1'b0);
      mem_req_ready_i = 1'b1;
      @(negedge clk);
      mem_req_ready_i = 1'b0;
      if (reset_in_wait) begin
         #2 rst_n = 1'b0;
         if_rd_m = '0;
         ls_rd_m = '0;
         #1;
         check_all_zero("rst_in_wait");
         @(negedge clk);
         #2 rst_n = 1'b1;
         @(negedge clk);
         mem_resp_valid_i = 1'b1;
         mem_rdata_i      = data;
         @(negedge clk);
         mem_resp_valid_i = 1'b0;
         repeat (4) @(negedge clk);
      end else begin
         mem_resp_valid_i = 1'b1;
         mem_rdata_i      = data;
         e.own = 1'b0; e.rdata = data; e.at = cyc + 1;
         rsp_q.push_back(e);
         @(negedge clk);
         mem_resp_valid_i = 1'b0;
         check("man_ls_resp_quiet", ls_resp_valid_o, 1'b0);
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin
      int modes[4] = '{100, 60, 25, 90};
      int waited;
      repeat (3) @(negedge clk);
      if_req_valid_i = 1'b1;
      ls_req_valid_i = 1'b1;
      #1;
      check_all_zero("reset");
      if_req_valid_i = 1'b0;
      ls_req_valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      run = 1;
      gen_en = 1;
      foreach (modes[i]) begin
         p_new = modes[i];
         repeat (400) @(negedge clk);
      end
      gen_en = 0;
      waited = 0;
      while ((if_pend || ls_pend || req_q.size() != 0 || rsp_q.size() != 0 || cyc < idle_at)
             && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 300) fail("drain_timeout");
      repeat (3) @(negedge clk);
      run = 0;
      @(negedge clk);
      mem_resp_valid_i = 1'b0;
      mem_req_ready_i  = 1'b0;
      if_req_valid_i   = 1'b0;
      ls_req_valid_i   = 1'b0;
      @(negedge clk);

      manual_if_read(64'h8000_0004, 64'h1122_3344_5566_7788, 1'b1);
      manual_if_read(64'h8000_0004, 64'h1122_3344_5566_7788, 1'b0);
      manual_if_read(64'h0000_1237, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
      if (rsp_q.size() != 0) fail("resp_queue_not_empty");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 64-bit data-memory port between instruction fetch (IF) and load/store (LS).
- Sits between the fetch/LS stages and the memory-side DPI/bus adapter.
- Runs one transaction at a time through a registered request/response FSM.
- LS has priority; a starvation counter guarantees IF forward progress.
- Byte-lane merging stays in the requester: LS supplies aligned wdata plus wstrb.

Parameters:
- XLEN, 64, data/address width.
- STARVE_LIMIT, 4, consecutive lost IDLE arbitration cycles after which a pending IF wins over LS.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
if_req_valid  input  1  IF read request pending
if_req_ready  output  1  IF request accepted this cycle
if_addr  input  XLEN  IF byte address
if_resp_valid  output  1  one-cycle pulse: IF read data valid
if_rdata  output  XLEN  IF read data, held until next IF response
ls_req_valid  input  1  LS request pending
ls_req_ready  output  1  LS request accepted this cycle
ls_addr  input  XLEN  LS byte address
ls_wen  input  1  1=write, 0=read
ls_wdata  input  XLEN  write data, already lane-aligned
ls_wstrb  input  8  byte write strobes
ls_resp_valid  output  1  one-cycle pulse: LS read data / write ack
ls_rdata  output  XLEN  LS read data, held until next LS response
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_addr  output  XLEN  8-byte-aligned address
mem_wen  output  1  write enable
mem_wdata  output  XLEN  write data
mem_wstrb  output  8  byte strobes
mem_resp_valid  input  1  memory response valid
mem_rdata  input  XLEN  memory read data

Behaviour:
- Clock and reset: clk only; rst_n asynchronous, active-low.
- Reset values:
  - state=IDLE.
  - All *_valid, *_ready, mem_wen = 0.
  - mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata = 0.
  - starve_cnt=0, owner=IF.
- States: IDLE, ISSUE, WAIT.
- IDLE arbitration (combinational ready; exactly one ready may be high):
  - LS valid only: LS wins.
  - IF valid only: IF wins.
  - Both valid: IF wins if starve_cnt==STARVE_LIMIT, else LS wins.
  - Winner's req_ready=1. On the same edge, latch owner, mem_addr=addr & ~7, mem_wen, mem_wdata, mem_wstrb; go to ISSUE.
  - IF transactions force mem_wen=0, wstrb=0, wdata=0.
  - LS reads (ls_wen=0) force wstrb=0.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on each IDLE cycle where IF is valid but LS is granted.
  - Clears when IF is granted.
  - Unchanged in ISSUE/WAIT.
- ISSUE: mem_req_valid=1 with latched fields held stable. On mem_req_ready=1, go to WAIT and drop mem_req_valid next cycle.
- WAIT: on mem_resp_valid=1, the next cycle pulses owner's resp_valid for 1 cycle and registers owner's rdata=mem_rdata; return to IDLE.
  - Writes also produce an LS ack pulse; ls_rdata updates with whatever mem_rdata carries.
- Latency, zero-wait memory (ready in ISSUE, response the cycle after the handshake):
  - accept at cycle T, mem_req_valid at T+1, mem_resp_valid at T+2, resp_valid at T+3.
  - Next request accepted at T+3 at earliest; IDLE coincides with the response pulse.
- mem_resp_valid outside WAIT is ignored; no state change and no pulse.
- Non-owner resp_valid stays 0; non-owner rdata keeps its old value.
- Requesters must hold valid/addr/data until ready. Dropping valid before ready is legal: no transaction is issued.
- Reset mid-transaction returns to IDLE immediately. The outstanding response is dropped and no pulse is emitted after reset release.
- Misaligned addresses are not checked; only the low 3 bits are cleared.

Test Plan:
- IF-only read, addr 0x8000_0004, mem_rdata 0x1122334455667788 with zero wait → mem_addr 0x8000_0000, mem_wen 0; if_resp_valid pulses exactly 3 cycles after accept with if_rdata 0x1122334455667788; ls_resp_valid stays 0.
- LS write, addr 0x8000_0013, wstrb 0x08, wdata 0xAB<<24 → mem_addr 0x8000_0010, mem_wen 1, mem_wstrb 0x08; mem_req_ready held low 3 cycles → mem_req_valid and fields stable across the stall; single ls_resp_valid pulse after mem_resp_valid.
- Both requesters valid continuously with STARVE_LIMIT=4 → grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; starve_cnt back to 0 after each IF grant.
- Spurious mem_resp_valid in IDLE and in ISSUE → no resp pulse, state and rdata registers unchanged.
- rst_n asserted in WAIT, memory response arrives after release → all outputs 0 immediately on assertion; no resp_valid pulse after release; next IF request is served normally.
- Back-to-back LS reads → the second accept coincides with the first ls_resp_valid pulse; ls_rdata correct for each read.
